// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: source count, register map
// and FSM state encoding.
package irq_pkg;

   localparam int NUM_SRC = 6;
   localparam int ID_W    = 3;

   localparam logic [31:0] ADDR_CTRL   = 32'h0000_7f20;
   localparam logic [31:0] ADDR_PEND   = 32'h0000_7f24;
   localparam logic [31:0] ADDR_ACTIVE = 32'h0000_7f28;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   // One-hot select of a source index, used for both ack-clear and mask lookup.
   function automatic logic [NUM_SRC-1:0] src_onehot(input logic [ID_W-1:0] idx);
      logic [NUM_SRC-1:0] one;
      one = {{(NUM_SRC-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt sources.
module irq_prio_enc
   import irq_pkg::*;
(
   input  logic [NUM_SRC-1:0] req,
   output logic [ID_W-1:0]    id,
   output logic               any
);

   always_comb begin
      id  = '0;
      any = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            id  = i[ID_W-1:0];
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Six-source interrupt controller with CTRL/PEND/ACTIVE bus registers and a
// non-nesting request/service handshake. Define IRQ_CTRL_EDGE_EN for edge capture.
module irq_ctrl
   import irq_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Addr,
   input  logic        WE,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   input  logic [5:0]  irq_in,
   output logic        int_req,
   output logic [2:0]  int_id,
   input  logic        int_ack,
   input  logic        eret
);

   state_t             state_q, state_d;
   logic               ge_q, ge_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               valid_q, valid_d;

   logic               wr_ctrl;
   logic               wr_pend;
   logic [NUM_SRC-1:0] irq_set;
   logic [NUM_SRC-1:0] w1c_clr;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] id_sel;
   logic               ctrl_kill;
   logic [ID_W-1:0]    enc_id;
   logic               enc_any;
   logic               unused_data;

   assign wr_ctrl     = WE && (Addr == ADDR_CTRL);
   assign wr_pend     = WE && (Addr == ADDR_PEND);
   assign unused_data = ^DataIn[31:7];

`ifdef IRQ_CTRL_EDGE_EN
   logic [NUM_SRC-1:0] irq_prev_q, irq_prev_d;

   always_comb begin
      irq_prev_d = irq_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) irq_prev_q <= '0;
      else       irq_prev_q <= irq_prev_d;
   end

   assign irq_set = irq_in & ~irq_prev_q;
`else
   assign irq_set = irq_in;
`endif

   irq_prio_enc u_prio_enc (
      .req (pend_q & mask_q),
      .id  (enc_id),
      .any (enc_any)
   );

   // A CTRL write that drops GE or the requesting source's mask cancels the request.
   assign id_sel    = src_onehot(id_q);
   assign ctrl_kill = wr_ctrl && (!DataIn[0] || ((DataIn[6:1] & id_sel) == '0));

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      valid_d = valid_q;
      ack_clr = '0;
      unique case (state_q)
         IDLE: begin
            if (ge_q && enc_any) begin
               id_d    = enc_id;
               state_d = REQ;
            end
         end
         REQ: begin
            if (int_ack) begin
               ack_clr = id_sel;
               valid_d = 1'b1;
               state_d = SERVICE;
            end else if (ctrl_kill) begin
               state_d = IDLE;
            end
         end
         SERVICE: begin
            if (eret) begin
               valid_d = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // New captures are OR'd in last so they win over any same-cycle clear.
   always_comb begin
      ge_d    = ge_q;
      mask_d  = mask_q;
      w1c_clr = wr_pend ? DataIn[NUM_SRC-1:0] : '0;
      if (wr_ctrl) begin
         ge_d   = DataIn[0];
         mask_d = DataIn[6:1];
      end
      pend_d = (pend_q & ~w1c_clr & ~ack_clr) | irq_set;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         ge_q    <= 1'b0;
         mask_q  <= '0;
         pend_q  <= '0;
         id_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ge_q    <= ge_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         id_q    <= id_d;
         valid_q <= valid_d;
      end
   end

   assign int_req = (state_q == REQ);
   assign int_id  = id_q;

   always_comb begin
      DataOut = '0;
      case (Addr)
         ADDR_CTRL:   DataOut = {25'b0, mask_q, ge_q};
         ADDR_PEND:   DataOut = {26'b0, pend_q};
         ADDR_ACTIVE: DataOut = {28'b0, valid_q, id_q};
         default:     DataOut = '0;
      endcase
   end

endmodule
